// File: rtl/mem_access_pkg.sv
// Shared types for the MEM stage.
//   reg_t        : writeback record {en, addr[4:0], data[31:0]}
//   mem_state_t  : data-bus initiator states
//   alu_op_t     : ALU op codes from the decode table
// Helper functions classify ALU ops for the memory path.
package mem_access_pkg;

    typedef logic [31:0] reg_data_t;
    typedef logic [31:0] ram_addr_t;

    typedef struct packed {
        logic       en;
        logic [4:0] addr;
        reg_data_t  data;
    } reg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [7:0] {
        NOP_OP = 8'h00,
        ADD_OP = 8'h20,
        SUB_OP = 8'h22,
        AND_OP = 8'h24,
        OR_OP  = 8'h25,
        LB_OP  = 8'h30,
        LW_OP  = 8'h33,
        SB_OP  = 8'h38,
        SW_OP  = 8'h3B
    } alu_op_t;

    function automatic logic is_mem_op(input alu_op_t op);
        return (op == LB_OP) || (op == LW_OP) || (op == SB_OP) || (op == SW_OP);
    endfunction

    function automatic logic is_byte_op(input alu_op_t op);
        return (op == LB_OP) || (op == SB_OP);
    endfunction

    function automatic logic is_store_op(input alu_op_t op);
        return (op == SB_OP) || (op == SW_OP);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus (purely combinational).
//   Store side: byte_op, st_lane, st_data -> be (byte enables), st_lanes
//               (byte stores replicate the low byte into all four lanes).
//   Load side : ld_lane, ld_word -> lb_data (little-endian byte at ld_lane,
//               sign-extended to 32 bits).
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic       byte_op,
    input  logic [1:0] st_lane,
    input  reg_data_t  st_data,
    output logic [3:0] be,
    output reg_data_t  st_lanes,
    input  logic [1:0] ld_lane,
    input  reg_data_t  ld_word,
    output reg_data_t  lb_data
);

    logic [7:0] ld_bytes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be[gi]              = !byte_op || (st_lane == 2'(gi));
        assign st_lanes[8*gi +: 8] = byte_op ? st_data[7:0] : st_data[8*gi +: 8];
        assign ld_bytes[gi]        = ld_word[8*gi +: 8];
    end

    assign lb_data = {{24{ld_bytes[ld_lane][7]}}, ld_bytes[ld_lane]};

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory initiator.
// Takes the EX/MEM record (op, effective address, store data, writeback
// record), runs one req/ack bus transaction per load/store while holding
// the pipeline, and returns the writeback record with load data inserted.
//   clk, rst            : clock, synchronous active-high reset
//   mem_valid_i/op_i/addr_i/wdata_i/wreg_i : EX/MEM inputs
//   stall_i             : pipeline held by another source (keeps DONE)
//   mem_wreg_o          : writeback record to MEM/WB
//   mem_stallreq        : stall request to pipeline control
//   mem_misalign_o      : misaligned LW/SW presented this cycle
//   mem_buserr_o        : one-cycle pulse when a request times out
//   dbus_*              : registered req/ack data-bus initiator
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  alu_op_t     mem_op_i,
    input  ram_addr_t   mem_addr_i,
    input  reg_data_t   mem_wdata_i,
    input  reg_t        mem_wreg_i,
    input  logic        stall_i,
    output reg_t        mem_wreg_o,
    output logic        mem_stallreq,
    output logic        mem_misalign_o,
    output logic        mem_buserr_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [3:0]  dbus_be_o,
    output ram_addr_t   dbus_addr_o,
    output reg_data_t   dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  reg_data_t   dbus_rdata_i
);

    mem_state_t state_reg;
    logic       req_reg;
    logic       we_reg;
    logic [3:0] be_reg;
    ram_addr_t  addr_reg;
    reg_data_t  wdata_reg;
    logic [7:0] cnt_reg;
    reg_data_t  rdata_reg;
    logic       error_reg;
    logic       buserr_reg;
    // Attributes of the in-flight instruction, captured at issue so the
    // DONE path does not depend on the EX/MEM register staying put.
    logic       byte_reg;
    logic       store_reg;
    logic [1:0] lane_reg;

    logic       mem_op;
    logic       byte_op;
    logic       misaligned;
    logic       issue;
    logic [3:0] be_next;
    reg_data_t  wdata_next;
    reg_data_t  lb_data;

    assign mem_op     = mem_valid_i && is_mem_op(mem_op_i);
    assign byte_op    = is_byte_op(mem_op_i);
    assign misaligned = mem_op && !byte_op && (mem_addr_i[1:0] != 2'b00);
    assign issue      = (state_reg == IDLE) && mem_op && !misaligned;

    mem_lane_align u_lane (
        .byte_op  (byte_op),
        .st_lane  (mem_addr_i[1:0]),
        .st_data  (mem_wdata_i),
        .be       (be_next),
        .st_lanes (wdata_next),
        .ld_lane  (lane_reg),
        .ld_word  (rdata_reg),
        .lb_data  (lb_data)
    );

    // Outputs toward the pipeline. Writeback is suppressed while a memory
    // op is still in flight; only the DONE cycle carries the real result.
    always_comb begin
        mem_wreg_o     = mem_wreg_i;
        mem_stallreq   = 1'b0;
        mem_misalign_o = 1'b0;
        case (state_reg)
            IDLE: begin
                if (misaligned) begin
                    mem_misalign_o = 1'b1;
                    mem_wreg_o.en  = 1'b0;
                end else if (mem_op) begin
                    mem_stallreq  = 1'b1;
                    mem_wreg_o.en = 1'b0;
                end
            end
            REQ: begin
                mem_stallreq  = 1'b1;
                mem_wreg_o.en = 1'b0;
            end
            DONE: begin
                if (store_reg) begin
                    mem_wreg_o.en = 1'b0;
                end else begin
                    mem_wreg_o.en   = mem_wreg_i.en & ~error_reg;
                    mem_wreg_o.data = byte_reg ? lb_data : rdata_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            req_reg    <= 1'b0;
            we_reg     <= 1'b0;
            be_reg     <= 4'h0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            cnt_reg    <= 8'd0;
            rdata_reg  <= '0;
            error_reg  <= 1'b0;
            buserr_reg <= 1'b0;
            byte_reg   <= 1'b0;
            store_reg  <= 1'b0;
            lane_reg   <= 2'b00;
        end else begin
            buserr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
                        we_reg    <= is_store_op(mem_op_i);
                        be_reg    <= be_next;
                        addr_reg  <= {mem_addr_i[31:2], 2'b00};
                        wdata_reg <= wdata_next;
                        cnt_reg   <= 8'd0;
                        error_reg <= 1'b0;
                        byte_reg  <= byte_op;
                        store_reg <= is_store_op(mem_op_i);
                        lane_reg  <= mem_addr_i[1:0];
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the last allowed
                    // cycle completes normally instead of timing out.
                    if (dbus_ack_i) begin
                        rdata_reg <= dbus_rdata_i;
                        req_reg   <= 1'b0;
                        cnt_reg   <= 8'd0;
                        state_reg <= DONE;
                    end else if (cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
                        req_reg    <= 1'b0;
                        cnt_reg    <= 8'd0;
                        error_reg  <= 1'b1;
                        buserr_reg <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    if (!stall_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dbus_req_o   = req_reg;
    assign dbus_we_o    = we_reg;
    assign dbus_be_o    = be_reg;
    assign dbus_addr_o  = addr_reg;
    assign dbus_wdata_o = wdata_reg;
    assign mem_buserr_o = buserr_reg;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_valid_i;
    alu_op_t    mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    reg_t       mem_wreg_i;
    logic       stall_i;
    reg_t       mem_wreg_o;
    logic       mem_stallreq;
    logic       mem_misalign_o;
    logic       mem_buserr_o;
    logic       dbus_req_o;
    logic       dbus_we_o;
    logic [3:0] dbus_be_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic       dbus_ack_i;
    logic [31:0] dbus_rdata_i;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid_i    (mem_valid_i),
        .mem_op_i       (mem_op_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_wreg_i     (mem_wreg_i),
        .stall_i        (stall_i),
        .mem_wreg_o     (mem_wreg_o),
        .mem_stallreq   (mem_stallreq),
        .mem_misalign_o (mem_misalign_o),
        .mem_buserr_o   (mem_buserr_o),
        .dbus_req_o     (dbus_req_o),
        .dbus_we_o      (dbus_we_o),
        .dbus_be_o      (dbus_be_o),
        .dbus_addr_o    (dbus_addr_o),
        .dbus_wdata_o   (dbus_wdata_o),
        .dbus_ack_i     (dbus_ack_i),
        .dbus_rdata_i   (dbus_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        reg_t wreg;
        bit   err;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference writeback record for a completed memory instruction.
    function automatic reg_t model_wreg(input alu_op_t op, input logic [31:0] addr,
                                        input logic [31:0] rd, input reg_t win, input bit err);
        reg_t r;
        logic [7:0] b;
        r = win;
        if (op == SB_OP || op == SW_OP) begin
            r.en = 1'b0;
        end else begin
            r.en = win.en && !err;
            if (op == LW_OP) begin
                r.data = rd;
            end else begin
                b = 8'(rd >> (8 * addr[1:0]));
                r.data = {{24{b[7]}}, b};
            end
        end
        return r;
    endfunction

    // One load/store: ack_at = REQ cycle carrying the ack (outside 1..TO
    // means no ack); hold = DONE cycles extended by stall_i.
    task automatic run_mem(input alu_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                           input reg_t win, input int ack_at, input logic [31:0] rd, input int hold);
        bit          is_byte;
        bit          is_store;
        bit          exp_err;
        int          exp_reqs;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        exp_t        e;
        exp_t        got_e;
        int          stalls;
        int          reqs;
        int          berr;
        bit          done;

        is_byte  = (op == LB_OP) || (op == SB_OP);
        is_store = (op == SB_OP) || (op == SW_OP);
        exp_err  = !(ack_at >= 1 && ack_at <= TO);
        exp_reqs = exp_err ? TO : ack_at;
        exp_be   = is_byte ? (4'b0001 << addr[1:0]) : 4'hF;
        exp_wd   = is_byte ? {4{wd[7:0]}} : wd;
        e.wreg   = model_wreg(op, addr, rd, win, exp_err);
        e.err    = exp_err;
        sb_q.push_back(e);

        mem_valid_i = 1'b1;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        mem_wreg_i  = win;
        stall_i     = 1'b0;
        stalls = 0;
        reqs   = 0;
        berr   = 0;
        done   = 1'b0;

        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (mem_buserr_o) berr++;
            if (mem_stallreq) stalls++;
            if (dbus_req_o) begin
                reqs++;
                check_eq("bus_addr", 64'(dbus_addr_o), 64'({addr[31:2], 2'b00}));
                check_eq("bus_be", 64'(dbus_be_o), 64'(exp_be));
                check_eq("bus_we", 64'(dbus_we_o), 64'(is_store));
                if (is_store) check_eq("bus_wdata", 64'(dbus_wdata_o), 64'(exp_wd));
                dbus_ack_i   = (reqs == ack_at);
                dbus_rdata_i = (reqs == ack_at) ? rd : $urandom();
            end else begin
                dbus_ack_i = 1'b0;
            end
            if (!mem_stallreq && stalls > 0) begin
                done  = 1'b1;
                got_e = sb_q.pop_front();
                check_eq("wb_en", 64'(mem_wreg_o.en), 64'(got_e.wreg.en));
                if (!got_e.err) check_eq("wb_rec", 64'(mem_wreg_o), 64'(got_e.wreg));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check_eq("txn_done_bound", 64'(0), 64'(1));

        // DONE extended by stall_i; stray acks here must not disturb anything.
        stall_i = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            dbus_ack_i   = 1'b1;
            dbus_rdata_i = $urandom();
            if (h == hold - 1) stall_i = 1'b0;
            @(negedge clk);
            if (mem_buserr_o) berr++;
            check_eq("hold_stall", 64'(mem_stallreq), 64'(0));
            check_eq("hold_req", 64'(dbus_req_o), 64'(0));
            check_eq("hold_wb_en", 64'(mem_wreg_o.en), 64'(e.wreg.en));
            if (!exp_err) check_eq("hold_wb_rec", 64'(mem_wreg_o), 64'(e.wreg));
        end
        @(posedge clk);
        #1;
        dbus_ack_i  = 1'b0;
        mem_valid_i = 1'b0;
        mem_op_i    = NOP_OP;
        @(negedge clk);
        if (mem_buserr_o) berr++;
        check_eq("idle_req", 64'(dbus_req_o), 64'(0));
        check_eq("stall_cycles", 64'(stalls), 64'(exp_reqs + 1));
        check_eq("req_cycles", 64'(reqs), 64'(exp_reqs));
        check_eq("buserr_pulses", 64'(berr), 64'(exp_err));
        $display("TXN op=%s addr=%08h ack_at=%0d reqs=%0d stalls=%0d buserr=%0d wb=%0h",
                 op.name(), addr, ack_at, reqs, stalls, berr, mem_wreg_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_op_t     ops[4];
        alu_op_t     op;
        logic [31:0] a;
        reg_t        w;
        reg_t        exp_w;
        bit          seen;

        ops = '{LB_OP, LW_OP, SB_OP, SW_OP};
        rst          = 1'b1;
        mem_valid_i  = 1'b0;
        mem_op_i     = NOP_OP;
        mem_addr_i   = '0;
        mem_wdata_i  = '0;
        mem_wreg_i   = '0;
        stall_i      = 1'b0;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 64'(dbus_req_o), 64'(0));
        check_eq("rst_we", 64'(dbus_we_o), 64'(0));
        check_eq("rst_be", 64'(dbus_be_o), 64'(0));
        check_eq("rst_addr", 64'(dbus_addr_o), 64'(0));
        check_eq("rst_wdata", 64'(dbus_wdata_o), 64'(0));
        check_eq("rst_buserr", 64'(mem_buserr_o), 64'(0));
        check_eq("rst_stall", 64'(mem_stallreq), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        run_mem(LW_OP, 32'h100, 32'h0, '{en: 1'b1, addr: 5'd8, data: 32'h0}, 3, 32'hDEADBEEF, 0);
        run_mem(LB_OP, 32'h203, 32'h0, '{en: 1'b1, addr: 5'd9, data: 32'h0}, 1, 32'h80FFFFFF, 0);
        run_mem(SB_OP, 32'h11, 32'h000000A5, '{en: 1'b1, addr: 5'd3, data: 32'h55}, 1, 32'h0, 0);
        run_mem(LW_OP, 32'h300, 32'h0, '{en: 1'b1, addr: 5'd4, data: 32'h0}, TO + 1, 32'h0, 2);
        run_mem(LW_OP, 32'h304, 32'h0, '{en: 1'b1, addr: 5'd5, data: 32'h0}, TO, 32'h12345678, 1);

        // Misaligned SW: no request, no stall, no writeback
        w = '{en: 1'b1, addr: 5'd7, data: 32'hCAFE};
        exp_w = w;
        exp_w.en = 1'b0;
        sb_q.push_back('{wreg: exp_w, err: 1'b0});
        mem_valid_i = 1'b1;
        mem_op_i    = SW_OP;
        mem_addr_i  = 32'h102;
        mem_wdata_i = 32'h11223344;
        mem_wreg_i  = w;
        @(negedge clk);
        check_eq("mis_flag", 64'(mem_misalign_o), 64'(1));
        check_eq("mis_stall", 64'(mem_stallreq), 64'(0));
        check_eq("mis_wb", 64'(mem_wreg_o), 64'(sb_q.pop_front().wreg));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mis_req", 64'(dbus_req_o), 64'(0));
        $display("TXN op=SW_OP addr=00000102 misaligned req=%0d", dbus_req_o);
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;

        // Randomised loads/stores, including timeouts and ack on the last cycle
        for (int i = 0; i < 8; i++) begin
            op = ops[$urandom_range(0, 3)];
            a  = $urandom();
            if (op == LW_OP || op == SW_OP) a[1:0] = 2'b00;
            w  = reg_t'({$urandom(), $urandom()});
            run_mem(op, a, $urandom(), w, $urandom_range(1, TO + 1), $urandom(), $urandom_range(0, 2));
        end

        // Reset in the middle of REQ, then a non-memory op
        mem_valid_i = 1'b1;
        mem_op_i    = LW_OP;
        mem_addr_i  = 32'h40;
        mem_wreg_i  = '{en: 1'b1, addr: 5'd2, data: 32'h0};
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            dbus_ack_i = 1'b0;
            if (dbus_req_o) seen = 1'b1;
        end
        check_eq("rstreq_seen", 64'(seen), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        w = '{en: 1'b1, addr: 5'd12, data: 32'h00001234};
        mem_op_i   = ADD_OP;
        mem_wreg_i = w;
        @(negedge clk);
        check_eq("rstreq_req", 64'(dbus_req_o), 64'(0));
        check_eq("rstreq_buserr", 64'(mem_buserr_o), 64'(0));
        check_eq("add_stall", 64'(mem_stallreq), 64'(0));
        check_eq("add_wb", 64'(mem_wreg_o), 64'(w));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("add_stall2", 64'(mem_stallreq), 64'(0));
        check_eq("add_req2", 64'(dbus_req_o), 64'(0));
        $display("TXN op=ADD_OP after reset wb=%0h stall=%0d", mem_wreg_o, mem_stallreq);
        mem_valid_i = 1'b0;

        check_eq("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage data-memory initiator of the MIPS pipeline.
- Consumes the EX-stage result: ALU op, effective RAM address, store data and writeback record.
- Runs the load/store transaction on a req/ack data bus, stalling the pipeline until it completes.
- Returns the writeback record: load data substituted for loads, passed through otherwise.

Parameters:
TIMEOUT_CYCLES, 255, REQ cycles without ack before abort with bus error (1..255).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
mem_valid_i  in  1  EX/MEM register holds a valid instruction
mem_op_i  in  alu_op_t  ALU op (LB_OP, LW_OP, SB_OP, SW_OP; others pass-through)
mem_addr_i  in  32  effective byte address
mem_wdata_i  in  32  store data (rt)
mem_wreg_i  in  reg_t  writeback record {en, addr[4:0], data[31:0]}
stall_i  in  1  pipeline held by another stall source
mem_wreg_o  out  reg_t  writeback record to MEM/WB
mem_stallreq  out  1  stall request to pipeline control
mem_misalign_o  out  1  misaligned LW/SW this cycle
mem_buserr_o  out  1  one-cycle pulse on bus timeout
dbus_req_o  out  1  request, registered
dbus_we_o  out  1  1 = store
dbus_be_o  out  4  byte enables
dbus_addr_o  out  32  word address {addr[31:2],2'b00}
dbus_wdata_o  out  32  store data
dbus_ack_i  in  1  one-cycle completion
dbus_rdata_i  in  32  load data, valid with ack

Behaviour:
- Reset: reset rst, synchronous, active-high.
- On reset: state IDLE; dbus_req_o/we/be/addr/wdata = 0; mem_buserr_o = 0; timeout counter = 0; load capture register = 0.
- States: IDLE, REQ, DONE.
- Memory op = mem_valid_i and op in {LB, LW, SB, SW}.
- Non-memory op: combinational pass-through, mem_wreg_o = mem_wreg_i; stallreq = 0; zero latency.
- IDLE, aligned memory op:
  - mem_stallreq = 1 combinationally.
  - Next edge: REQ, with dbus_req_o = 1 and bus fields registered.
  - Byte ops: be = 4'b0001 << addr[1:0]; wdata = store byte replicated in all four lanes.
  - Word ops: be = 4'hF.
- Misaligned LW/SW (addr[1:0] != 0):
  - No request; stay IDLE.
  - mem_misalign_o = 1 combinationally; mem_wreg_o.en = 0; stallreq = 0.
- REQ:
  - stallreq = 1; bus outputs held stable.
  - Counter increments each cycle.
  - On ack: capture rdata; next edge DONE with dbus_req_o = 0.
  - Counter reaching TIMEOUT_CYCLES without ack: next edge DONE with req = 0, mem_buserr_o = 1 for one cycle, error flag set.
- DONE:
  - stallreq = 0.
  - mem_wreg_o = {mem_wreg_i.en & ~error, mem_wreg_i.addr, loaddata}.
  - LB: loaddata = sign-extended byte at lane addr[1:0] (little-endian).
  - LW: loaddata = captured word.
  - Stores: data = mem_wreg_i.data, en forced 0.
  - Next edge: IDLE if !stall_i; else remain DONE, outputs held.
- Ack outside REQ: ignored.
- Ack in the same cycle the timeout expires: ack wins, no error.
- Reset mid-REQ: IDLE next edge; req drops; no buserr; no writeback.
- Each memory instruction issues exactly one request; a new instruction is only sampled in IDLE.

Decomposition:
- Shared package project_types: reg_t, reg_data_t, ram_addr_t, mem_state_t enum (IDLE, REQ, DONE).
- decode_table: existing alu_op_t codes.
- Sub-module mem_lane_align: combinational byte-enable/write-lane generation plus LB extract and sign-extend.

Test Plan:
- LW addr 0x100, ack after 3 REQ cycles with rdata 0xDEADBEEF:
  - dbus_addr 0x100, be 0xF, stallreq high 4 cycles.
  - DONE: wreg.data 0xDEADBEEF, en 1.
- LB addr 0x203, rdata 0x80FFFFFF:
  - be 0x8, dbus_addr 0x200.
  - wreg.data 0xFFFFFF80.
- SB addr 0x11, wdata 0x000000A5, immediate ack:
  - we 1, be 0x2, wdata 0xA5A5A5A5.
  - wreg.en 0.
- SW addr 0x102:
  - mem_misalign_o 1, no dbus_req, stallreq 0, wreg.en 0.
- LW with TIMEOUT_CYCLES = 4, no ack:
  - REQ exactly 4 cycles, buserr pulse 1 cycle, wreg.en 0, back to IDLE.
- Reset during REQ, then ADD_OP:
  - req 0 next cycle.
  - ADD result passed through unchanged, stallreq 0.
